cache_refill_arbiter: RTL and testbench
=======================================

# cache_refill_arbiter

Shares one main-memory read port between the instruction-cache and data-cache refill engines. Each requester asks for a full cache block: BEATS consecutive 64-bit words starting at a block-aligned address. The arbiter serialises these requests with round-robin fairness, drives the memory request/acknowledge handshake and returns the read beats to the granted requester. It sits between the two Cache miss-handling state machines and the main-memory controller.

## Interface
- ADDR_W, 32, word address width
- DATA_W, 64, data word width
- BEATS, 4, words per block (power of two, ≥2)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  refill request from requester 0 (icache) / 1 (dcache); level, held until grant
- addr0 / addr1  in  ADDR_W  word address of the missing word
- grant0 / grant1  out  1  one-cycle pulse: request accepted
- rvalid0 / rvalid1  out  1  beat valid for requester 0 / 1
- rdata  out  DATA_W  beat data, shared by both requesters
- rlast  out  1  final beat of the burst, coincides with rvalid
- busy  out  1  high in any state other than IDLE
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  block base address
- mem_ack  in  1  memory accepts the request when mem_req && mem_ack
- mem_rvalid  in  1  memory returns one beat
- mem_rdata  in  DATA_W  beat data

## Operation
- The FSM has three states: IDLE, ISSUE and BURST. It holds a 1-bit round-robin pointer `last_served` and a beat counter of width log2(BEATS).
- **IDLE**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, that requester wins.
  - If both are high, the requester ≠ last_served wins.
  - On a win:
    - Pulse the winner's grant.
    - Latch the owner.
    - Set mem_addr = winner's addr with the low log2(BEATS) bits cleared.
    - Set mem_req=1, clear the beat counter and go to ISSUE.
- **ISSUE**
  - Hold mem_req and mem_addr stable until mem_ack is sampled high.
  - Then mem_req=0 and go to BURST.
- **BURST**
  - Each cycle mem_rvalid=1:
    - Register mem_rdata into rdata.
    - Assert the owner's rvalid and increment the beat counter.
  - On beat BEATS-1:
    - Also assert rlast.
    - Set last_served=owner and go to IDLE.
  - Cycles with mem_rvalid=0 are stalls: the counter holds and both rvalid outputs are 0.
- **Ignored inputs**
  - mem_rvalid is ignored in IDLE and ISSUE. Memory guarantees the first beat no earlier than the cycle after acceptance.
  - Requests are ignored outside IDLE. A requester that is still high, or whose req rises again, is evaluated in the next IDLE cycle.
- **Reset**
  - Asynchronous; may occur at any point, including mid-burst.
  - The FSM returns to IDLE, last_served=1 (requester 0 wins the first tie) and the counter is 0.
  - Every output is 0: grant0/1, rvalid0/1, rdata, rlast, busy, mem_req, mem_addr.
  - A burst in flight is abandoned; the requester re-requests.
- Widths: the counter wraps naturally at BEATS. Address alignment is a mask only; no arithmetic on mem_addr.

## Timing
- All outputs are registered.
- A request sampled in IDLE at edge k gives grant, mem_req, mem_addr and busy high in cycle k+1.
- The memory handshake is same-cycle: a transfer occurs at the edge where mem_req && mem_ack.
- A beat sampled at edge j appears on rvalid/rdata in cycle j+1.
- After the last beat is sampled, the FSM is in IDLE the next cycle and can accept a new request there.
- Minimum occupancy, from grant to back in IDLE: 1 (ISSUE, immediate ack) + BEATS cycles.
- busy is high from cycle k+1 through the cycle in which rlast is presented.

## Test plan
- **Single request:** req0 with addr0=0x0000_0106, mem_ack immediate, 4 back-to-back beats 0xA0..0xA3.
  - grant0 pulses once and mem_addr=0x0000_0104.
  - rvalid0 shows 4 beats A0..A3, with rlast on A3; rvalid1 stays 0.
- **Simultaneous after reset:** req0 and req1 both high.
  - Requester 0 is served first, then requester 1 immediately after.
  - grant1 rises the cycle after rlast; each requester gets 4 beats.
- **Fairness:** req0 and req1 both held high continuously for 4 bursts.
  - Grants alternate 0,1,0,1 and no requester is served twice in a row.
- **Stalls:** mem_ack delayed 3 cycles; mem_rvalid pattern 1,0,0,1,1,0,1.
  - mem_req and mem_addr stay stable until ack.
  - Exactly 4 rvalid pulses occur, one cycle after each mem_rvalid, with rlast on the 4th.
- **Reset mid-burst:** reset asserted after 2 of 4 beats.
  - All outputs go to 0 immediately.
  - The next req1 is granted and the burst completes from beat 0.
- **Stray data:** mem_rvalid pulsed in IDLE and in ISSUE.
  - No rvalid is produced and the beat count is unaffected.

Source files
------------

// File: rtl/cache_refill_arbiter.sv
// Round-robin arbiter sharing one main-memory read port between the icache and
// dcache refill engines; serialises whole-block bursts and routes beats back.
module cache_refill_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BEATS  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              grant0,
    output logic              grant1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              rlast,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

    state_t              state, state_n;
    logic                owner, owner_n;
    logic                last_served, last_served_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                grant0_n, grant1_n, rvalid0_n, rvalid1_n, rlast_n, busy_n, mem_req_n;
    logic [DATA_W-1:0]   rdata_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic                winner;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_n       = state;
        owner_n       = owner;
        last_served_n = last_served;
        cnt_n         = cnt;
        grant0_n      = 1'b0;
        grant1_n      = 1'b0;
        rvalid0_n     = 1'b0;
        rvalid1_n     = 1'b0;
        rlast_n       = 1'b0;
        rdata_n       = rdata;
        mem_req_n     = mem_req;
        mem_addr_n    = mem_addr;
        // On a tie the requester that was not served last wins.
        winner        = (req0 && req1) ? ~last_served : req1;

        case (state)
            IDLE: begin
                mem_req_n = 1'b0;
                if (req0 || req1) begin
                    grant0_n   = ~winner;
                    grant1_n   = winner;
                    owner_n    = winner;
                    mem_addr_n = (winner ? addr1 : addr0) & ALIGN_MASK;
                    mem_req_n  = 1'b1;
                    cnt_n      = '0;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    mem_req_n = 1'b0;
                    state_n   = BURST;
                end
            end
            BURST: begin
                if (mem_rvalid) begin
                    rdata_n   = mem_rdata;
                    rvalid0_n = ~owner;
                    rvalid1_n = owner;
                    cnt_n     = cnt + 1'b1;
                    if (cnt == LAST_BEAT) begin
                        rlast_n       = 1'b1;
                        last_served_n = owner;
                        state_n       = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // busy also covers the cycle presenting rlast, when the FSM is already back in IDLE.
        busy_n = (state_n != IDLE) || rlast_n;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            cnt         <= '0;
            grant0      <= 1'b0;
            grant1      <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rlast       <= 1'b0;
            rdata       <= '0;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            last_served <= last_served_n;
            cnt         <= cnt_n;
            grant0      <= grant0_n;
            grant1      <= grant1_n;
            rvalid0     <= rvalid0_n;
            rvalid1     <= rvalid1_n;
            rlast       <= rlast_n;
            rdata       <= rdata_n;
            busy        <= busy_n;
            mem_req     <= mem_req_n;
            mem_addr    <= mem_addr_n;
        end
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed self-checking bench for cache_refill_arbiter: single request, ties,
// fairness, memory stalls, reset mid-burst and stray beats outside BURST.
module tb_cache_refill_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        grant0, grant1, rvalid0, rvalid1, rlast, busy, mem_req;
    logic [63:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_ack, mem_rvalid;
    logic [63:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int waited;

    cache_refill_arbiter #(.ADDR_W(32), .DATA_W(64), .BEATS(4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .grant0(grant0), .grant1(grant1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .rlast(rlast), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clock);
    endtask

    // Waits for a grant, checks it, runs the handshake and the beat pattern
    // (bit i of pat = mem_rvalid in the i-th burst cycle).
    task automatic serve(input bit who, input logic [31:0] exp_addr, input logic [63:0] base,
                         input int ack_delay, input bit stray, input logic [7:0] pat,
                         input int pat_len, input bit drop, output int wait_cycles);
        bit got = 1'b0;
        int beats = 0;
        wait_cycles = 0;
        while (!got && wait_cycles < 10) begin
            tick();
            wait_cycles++;
            if (grant0 || grant1) got = 1'b1;
        end
        if (!got) begin
            check("grant_timeout", 0, 1);
            return;
        end
        check("grant_who", {grant1, grant0}, who ? 2'b10 : 2'b01);
        check("mem_addr", mem_addr, exp_addr);
        check("mem_req_set", mem_req, 1);
        check("busy_set", busy, 1);
        if (drop) begin
            if (who) req1 = 1'b0;
            else     req0 = 1'b0;
        end
        for (int i = 0; i < ack_delay; i++) begin
            mem_rvalid = stray;
            tick();
            check("hold_req", mem_req, 1);
            check("hold_addr", mem_addr, exp_addr);
            check("no_rvalid_issue", {rvalid1, rvalid0}, 0);
            check("grant_pulse", {grant1, grant0}, 0);
        end
        mem_rvalid = 1'b0;
        mem_ack    = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("mem_req_clear", mem_req, 0);
        check("grant_pulse", {grant1, grant0}, 0);
        for (int i = 0; i < pat_len; i++) begin
            mem_rvalid = pat[i];
            mem_rdata  = base + 64'(beats);
            tick();
            check("rvalid_owner", who ? rvalid1 : rvalid0, pat[i]);
            check("rvalid_other", who ? rvalid0 : rvalid1, 0);
            if (pat[i]) begin
                check("rdata", rdata, base + 64'(beats));
                beats++;
            end
            check("rlast", rlast, (pat[i] && beats == 4) ? 1 : 0);
            check("busy_burst", busy, 1);
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
        mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;

        // Reset state
        tick();
        check("rst_ctrl", {grant0, grant1, rvalid0, rvalid1, rlast, busy, mem_req}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", rdata, 0);
        reset = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Single request, unaligned address
        req0 = 1; addr0 = 32'h0000_0106;
        serve(0, 32'h0000_0104, 64'hA0, 0, 0, 8'h0F, 4, 1, waited);
        check("single_latency", waited, 1);
        tick();
        check("single_done_busy", busy, 0);
        check("single_done_rv", {rvalid1, rvalid0, rlast, grant1, grant0}, 0);

        // Simultaneous requests after reset: 0 first, 1 back-to-back
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1; req1 = 1; addr0 = 32'h0000_1000; addr1 = 32'h0000_2007;
        serve(0, 32'h0000_1000, 64'hB0, 0, 0, 8'h0F, 4, 1, waited);
        serve(1, 32'h0000_2004, 64'hB8, 0, 0, 8'h0F, 4, 1, waited);
        check("b2b_gap", waited, 1);

        // Fairness: both held continuously for four bursts
        req0 = 1; req1 = 1;
        serve(0, 32'h0000_1000, 64'h100, 0, 0, 8'h0F, 4, 0, waited);
        serve(1, 32'h0000_2004, 64'h110, 0, 0, 8'h0F, 4, 0, waited);
        check("fair_gap1", waited, 1);
        serve(0, 32'h0000_1000, 64'h120, 0, 0, 8'h0F, 4, 0, waited);
        serve(1, 32'h0000_2004, 64'h130, 0, 0, 8'h0F, 4, 0, waited);
        check("fair_gap3", waited, 1);
        req0 = 0; req1 = 0;
        tick();
        check("fair_no_regrant", {grant1, grant0, busy}, 0);

        // Stalls: ack after 3 cycles, beat pattern 1,0,0,1,1,0,1; top-of-range address
        req0 = 1; addr0 = 32'hFFFF_FFFF;
        serve(0, 32'hFFFF_FFFC, 64'hE0, 3, 0, 8'b0101_1001, 7, 1, waited);
        tick();
        check("stall_done_busy", busy, 0);

        // Reset mid-burst after two beats
        req1 = 1; addr1 = 32'h0000_2A3B;
        tick();
        check("mid_grant", grant1, 1);
        check("mid_addr", mem_addr, 32'h0000_2A38);
        req1 = 0; mem_ack = 1;
        tick();
        mem_ack = 0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1; mem_rdata = 64'hC0 + 64'(i);
            tick();
        end
        check("mid_beat2", rdata, 64'hC1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ctrl", {grant0, grant1, rvalid0, rvalid1, rlast, busy, mem_req}, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_data", rdata, 0);
        mem_rvalid = 0;
        tick();
        reset = 1'b0;
        req1 = 1;
        serve(1, 32'h0000_2A38, 64'hD0, 0, 0, 8'h0F, 4, 1, waited);

        // Stray beats in IDLE and ISSUE
        tick();
        mem_rvalid = 1; mem_rdata = 64'hDEAD;
        tick();
        check("stray_idle_rv", {rvalid1, rvalid0, busy}, 0);
        mem_rvalid = 0;
        req1 = 1; addr1 = 32'h0000_0041;
        serve(1, 32'h0000_0040, 64'hF0, 2, 1, 8'h0F, 4, 1, waited);
        tick();
        check("stray_done_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
